// File: rtl/centroid_extractor.sv
// Post-frame ROI readout: sweeps the label data table, divides moment sums by area
// and streams one (id, area, cx, cy) record per non-empty label.
//
// state  | meaning
// IDLE   | waiting for start
// ADDR   | obj_id holds current label, arm read-latency counter
// WAIT   | let the data-table read settle
// LATCH  | capture area/sum_x/sum_y, skip empty labels
// DIV    | serial restoring divide, one quotient bit per cycle
// OUT    | record presented until accepted
// FIN    | pulse done, drop busy, rewind obj_id
module centroid_extractor #(
    parameter int LBL_W    = 12,
    parameter int LOC_W    = 32,
    parameter int READ_LAT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LBL_W-1:0] num_labels,
    output logic [LBL_W-1:0] obj_id,
    input  logic [LOC_W-1:0] obj_area,
    input  logic [LOC_W-1:0] obj_x,
    input  logic [LOC_W-1:0] obj_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LBL_W-1:0] out_id,
    output logic [LOC_W-1:0] out_area,
    output logic [LOC_W-1:0] out_cx,
    output logic [LOC_W-1:0] out_cy,
    output logic             busy,
    output logic             done
);

    localparam int CNT_MAX = (LOC_W > READ_LAT) ? LOC_W : READ_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WAIT, S_LATCH, S_DIV, S_OUT, S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [LBL_W-1:0] obj_id_q, obj_id_d;
    logic [LBL_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LOC_W-1:0] area_q, area_d;
    logic [LOC_W-1:0] rem_x_q, rem_x_d, quo_x_q, quo_x_d;
    logic [LOC_W-1:0] rem_y_q, rem_y_d, quo_y_q, quo_y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LBL_W-1:0] out_id_q, out_id_d;
    logic [LOC_W-1:0] out_area_q, out_area_d;
    logic [LOC_W-1:0] out_cx_q, out_cx_d;
    logic [LOC_W-1:0] out_cy_q, out_cy_d;

    logic [LOC_W-1:0] rem_x_nx, quo_x_nx, rem_y_nx, quo_y_nx;
    logic             last_lbl;

    // One restoring step: the quotient register starts as the dividend and shifts its
    // MSB into the partial remainder while quotient bits shift in at the bottom.
    function automatic logic [2*LOC_W-1:0] div_step(
        input logic [LOC_W-1:0] rem,
        input logic [LOC_W-1:0] quo,
        input logic [LOC_W-1:0] dvs
    );
        logic [LOC_W:0] trial;
        trial = {rem, quo[LOC_W-1]};
        if (trial >= {1'b0, dvs}) begin
            div_step = {trial[LOC_W-1:0] - dvs, quo[LOC_W-2:0], 1'b1};
        end else begin
            div_step = {trial[LOC_W-1:0], quo[LOC_W-2:0], 1'b0};
        end
    endfunction

    always_comb begin
        {rem_x_nx, quo_x_nx} = div_step(rem_x_q, quo_x_q, area_q);
        {rem_y_nx, quo_y_nx} = div_step(rem_y_q, quo_y_q, area_q);
    end

    assign last_lbl = (obj_id_q == num_q);

    always_comb begin
        state_d    = state_q;
        obj_id_d   = obj_id_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        area_d     = area_q;
        rem_x_d    = rem_x_q;
        quo_x_d    = quo_x_q;
        rem_y_d    = rem_y_q;
        quo_y_d    = quo_y_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        out_id_d   = out_id_q;
        out_area_d = out_area_q;
        out_cx_d   = out_cx_q;
        out_cy_d   = out_cy_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d    = num_labels;
                    obj_id_d = LBL_W'(1);
                    busy_d   = 1'b1;
                    state_d  = (num_labels == '0) ? S_FIN : S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_d   = CNT_W'(READ_LAT - 1);
                state_d = (READ_LAT <= 1) ? S_LATCH : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                area_d  = obj_area;
                quo_x_d = obj_x;
                quo_y_d = obj_y;
                rem_x_d = '0;
                rem_y_d = '0;
                cnt_d   = CNT_W'(LOC_W - 1);
                if (obj_area != '0) begin
                    state_d = S_DIV;
                end else if (last_lbl) begin
                    state_d = S_FIN;
                end else begin
                    obj_id_d = obj_id_q + LBL_W'(1);
                    state_d  = S_ADDR;
                end
            end
            S_DIV: begin
                rem_x_d = rem_x_nx;
                quo_x_d = quo_x_nx;
                rem_y_d = rem_y_nx;
                quo_y_d = quo_y_nx;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    out_id_d   = obj_id_q;
                    out_area_d = area_q;
                    out_cx_d   = quo_x_nx;
                    out_cy_d   = quo_y_nx;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (last_lbl) begin
                        state_d = S_FIN;
                    end else begin
                        obj_id_d = obj_id_q + LBL_W'(1);
                        state_d  = S_ADDR;
                    end
                end
            end
            S_FIN: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                obj_id_d = LBL_W'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            obj_id_q   <= LBL_W'(1);
            num_q      <= '0;
            cnt_q      <= '0;
            area_q     <= '0;
            rem_x_q    <= '0;
            quo_x_q    <= '0;
            rem_y_q    <= '0;
            quo_y_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_id_q   <= '0;
            out_area_q <= '0;
            out_cx_q   <= '0;
            out_cy_q   <= '0;
        end else begin
            state_q    <= state_d;
            obj_id_q   <= obj_id_d;
            num_q      <= num_d;
            cnt_q      <= cnt_d;
            area_q     <= area_d;
            rem_x_q    <= rem_x_d;
            quo_x_q    <= quo_x_d;
            rem_y_q    <= rem_y_d;
            quo_y_q    <= quo_y_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            out_id_q   <= out_id_d;
            out_area_q <= out_area_d;
            out_cx_q   <= out_cx_d;
            out_cy_q   <= out_cy_d;
        end
    end

    assign obj_id    = obj_id_q;
    assign out_valid = (state_q == S_OUT);
    assign out_id    = out_id_q;
    assign out_area  = out_area_q;
    assign out_cx    = out_cx_q;
    assign out_cy    = out_cy_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
